// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Word-addressed data RAM plus a 16-byte MMIO register window
//               (GPIO, free-running COUNT/CMP timer, CTRL) for a small core.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  GpioOut,
  output logic        TimerIrq
);

  localparam int          c_aw        = $clog2(DEPTH);
  localparam logic [31:0] c_ram_bytes = 32'(DEPTH * 4);
  localparam logic [1:0]  c_reg_gpio  = 2'd0;
  localparam logic [1:0]  c_reg_count = 2'd1;
  localparam logic [1:0]  c_reg_cmp   = 2'd2;
  localparam logic [1:0]  c_reg_ctrl  = 2'd3;

  // Word storage; deliberately not reset.
  logic [31:0] r_mem [DEPTH];

  logic [7:0]  r_gpio;
  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_match;
  logic        r_en;
  logic        r_ie;
  logic        r_irq;

  logic            w_ram_hit;
  logic            w_mmio_hit;
  logic [c_aw-1:0] w_word_idx;
  logic [1:0]      w_reg_idx;
  logic            w_wr_gpio;
  logic            w_wr_count;
  logic            w_wr_cmp;
  logic            w_wr_ctrl;
  logic            w_match_now;
  logic [31:0]     w_count_next;

  // RAM occupies the bottom of the address space; the register window is
  // only decoded where it does not overlap RAM. Byte offset bits are ignored.
  assign w_ram_hit  = (Addr < c_ram_bytes);
  assign w_mmio_hit = (Addr[31:4] == MMIO_BASE[31:4]) && !w_ram_hit;
  assign w_word_idx = Addr[c_aw+1:2];
  assign w_reg_idx  = Addr[3:2];

  assign w_wr_gpio  = MemWrite && w_mmio_hit && (w_reg_idx == c_reg_gpio);
  assign w_wr_count = MemWrite && w_mmio_hit && (w_reg_idx == c_reg_count);
  assign w_wr_cmp   = MemWrite && w_mmio_hit && (w_reg_idx == c_reg_cmp);
  assign w_wr_ctrl  = MemWrite && w_mmio_hit && (w_reg_idx == c_reg_ctrl);

  // Compare uses the pre-write COUNT and the currently registered EN, so a
  // CTRL write only affects counting from the following cycle.
  assign w_match_now = r_en && (r_count == r_cmp);

  // Next COUNT: software write wins, then compare-wrap, then increment.
  always_comb begin
    w_count_next = r_count;
    if (w_wr_count) begin
      w_count_next = WriteData;
    end else if (r_en) begin
      w_count_next = w_match_now ? 32'd0 : (r_count + 32'd1);
    end
  end

  // RAM write port; stores arriving while reset is held are dropped.
  always_ff @(posedge clk) begin
    if (MemWrite && w_ram_hit && rst) begin
      r_mem[w_word_idx] <= WriteData;
    end
  end

  // Register file, timer and interrupt state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gpio  <= 8'd0;
      r_count <= 32'd0;
      r_cmp   <= 32'd0;
      r_match <= 1'b0;
      r_en    <= 1'b0;
      r_ie    <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_wr_gpio) begin
        r_gpio <= WriteData[7:0];
      end
      if (w_wr_cmp) begin
        r_cmp <= WriteData;
      end
      if (w_wr_ctrl) begin
        r_en <= WriteData[1];
        r_ie <= WriteData[2];
      end
      // A new match beats a simultaneous write-1-to-clear.
      if (w_match_now) begin
        r_match <= 1'b1;
      end else if (w_wr_ctrl && WriteData[0]) begin
        r_match <= 1'b0;
      end
      r_irq <= r_match && r_ie;
    end
  end

  // Combinational read mux; unmapped space and unimplemented bits read 0.
  always_comb begin
    ReadData = 32'd0;
    if (w_ram_hit) begin
      ReadData = r_mem[w_word_idx];
    end else if (w_mmio_hit) begin
      case (w_reg_idx)
        c_reg_gpio:  ReadData = {24'd0, r_gpio};
        c_reg_count: ReadData = r_count;
        c_reg_cmp:   ReadData = r_cmp;
        default:     ReadData = {29'd0, r_ie, r_en, r_match};
      endcase
    end
  end

  assign GpioOut  = r_gpio;
  assign TimerIrq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench for data_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam logic [31:0] c_base  = 32'h0000_1000;
  localparam logic [31:0] c_gpio  = c_base + 32'h0;
  localparam logic [31:0] c_count = c_base + 32'h4;
  localparam logic [31:0] c_cmp   = c_base + 32'h8;
  localparam logic [31:0] c_ctrl  = c_base + 32'hC;

  logic        clk;
  logic        rst;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  GpioOut;
  logic        TimerIrq;

  int n_vec;
  int n_err;

  data_mem_responder #(
    .DEPTH     (64),
    .MMIO_BASE (c_base)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .GpioOut   (GpioOut),
    .TimerIrq  (TimerIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: one write on the next posedge, returns at the negedge after.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr      = a;
    WriteData = d;
    MemWrite  = 1'b1;
    @(negedge clk);
    MemWrite  = 1'b0;
  endtask

  // Combinational read check, taken mid low-phase.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(tag, ReadData, exp);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b0;
    MemWrite  = 1'b0;
    Addr      = 32'd0;
    WriteData = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gpio", {24'd0, GpioOut}, 32'd0);
    chk("rst_irq", {31'd0, TimerIrq}, 32'd0);
    rd("rst_count", c_count, 32'd0);
    rd("rst_ctrl", c_ctrl, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // RAM: byte offset ignored, first/last words, out-of-range space
    wr(32'h0000_0008, 32'hDEAD_BEEF);
    rd("ram_08", 32'h0000_0008, 32'hDEAD_BEEF);
    rd("ram_0b", 32'h0000_000B, 32'hDEAD_BEEF);
    wr(32'h0000_0000, 32'h1234_5678);
    wr(32'h0000_00FE, 32'hCAFE_F00D);
    wr(32'h0000_0010, 32'h0000_0011);
    rd("ram_00", 32'h0000_0000, 32'h1234_5678);
    rd("ram_fc", 32'h0000_00FC, 32'hCAFE_F00D);
    rd("ram_10", 32'h0000_0010, 32'h0000_0011);
    wr(32'h0000_0100, 32'h5555_5555);
    rd("unmapped_100", 32'h0000_0100, 32'd0);

    // GPIO and unimplemented bits
    wr(c_gpio, 32'h0000_01A5);
    chk("gpio_out", {24'd0, GpioOut}, 32'h0000_00A5);
    rd("gpio_rd", c_gpio, 32'h0000_00A5);
    rd("unmapped_1010", c_base + 32'h10, 32'd0);

    // Timer: CMP=3, EN|IE -> 0,1,2,3,0
    wr(c_cmp, 32'd3);
    rd("cmp_rd", c_cmp, 32'd3);
    @(negedge clk);
    wr(c_ctrl, 32'h6);
    rd("cnt_0", c_count, 32'd0);
    @(negedge clk); rd("cnt_1", c_count, 32'd1);
    @(negedge clk); rd("cnt_2", c_count, 32'd2);
    @(negedge clk); rd("cnt_3", c_count, 32'd3);
    @(negedge clk); rd("cnt_wrap", c_count, 32'd0);
    rd("ctrl_match", c_ctrl, 32'h7);
    chk("irq_wrap_edge", {31'd0, TimerIrq}, 32'd0);
    @(negedge clk);
    chk("irq_next_edge", {31'd0, TimerIrq}, 32'd1);
    rd("cnt_after", c_count, 32'd1);

    // W1C coincident with a new match: set wins
    @(negedge clk); rd("cnt_2b", c_count, 32'd2);
    @(negedge clk); rd("cnt_3b", c_count, 32'd3);
    wr(c_ctrl, 32'h7);
    rd("w1c_vs_match", c_ctrl, 32'h7);
    rd("cnt_wrap_b", c_count, 32'd0);
    // W1C without a match clears MATCH; IRQ drops one edge later
    wr(c_ctrl, 32'h7);
    rd("w1c_clear", c_ctrl, 32'h6);
    chk("irq_still_1", {31'd0, TimerIrq}, 32'd1);
    @(negedge clk);
    chk("irq_drop", {31'd0, TimerIrq}, 32'd0);
    rd("cnt_2c", c_count, 32'd2);

    // EN=0: last increment with old EN, then hold with no match at COUNT==CMP
    wr(c_ctrl, 32'h0);
    rd("cnt_3c", c_count, 32'd3);
    @(negedge clk);
    rd("cnt_hold", c_count, 32'd3);
    rd("no_match_dis", c_ctrl, 32'h0);

    // Wrap at all-ones without hitting CMP
    wr(c_count, 32'hFFFF_FFFF);
    wr(c_cmp, 32'd5);
    wr(c_ctrl, 32'h2);
    rd("cnt_ff", c_count, 32'hFFFF_FFFF);
    @(negedge clk);
    rd("cnt_ff_wrap", c_count, 32'd0);
    rd("ctrl_nomatch", c_ctrl, 32'h2);

    // COUNT write wins over compare-wrap, MATCH still set
    repeat (5) @(negedge clk);
    rd("cnt_5", c_count, 32'd5);
    wr(c_count, 32'd100);
    rd("cnt_wr_prio", c_count, 32'd100);
    rd("ctrl_match_wr", c_ctrl, 32'h3);
    wr(c_ctrl, 32'h6);
    chk("irq_ie_lag", {31'd0, TimerIrq}, 32'd0);
    rd("cnt_101", c_count, 32'd101);
    @(negedge clk);
    chk("irq_ie_set", {31'd0, TimerIrq}, 32'd1);

    // Asynchronous reset mid-count, away from any clock edge
    #2;
    rst = 1'b0;
    #1;
    chk("arst_irq", {31'd0, TimerIrq}, 32'd0);
    chk("arst_gpio", {24'd0, GpioOut}, 32'd0);
    rd("arst_count", c_count, 32'd0);
    rd("arst_ctrl", c_ctrl, 32'd0);
    rd("arst_2000", 32'h0000_2000, 32'd0);
    rd("ram_keep", 32'h0000_0008, 32'hDEAD_BEEF);

    // Writes seen at an edge while reset is still low are ignored
    @(negedge clk);
    Addr = c_gpio; WriteData = 32'h55; MemWrite = 1'b1;
    @(negedge clk);
    Addr = 32'h0000_0010; WriteData = 32'h77;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
    chk("rst_wr_gpio", {24'd0, GpioOut}, 32'd0);
    rd("rst_wr_ram", 32'h0000_0010, 32'h0000_0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
